// File: rtl/isu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Entry layout pairs each fetched word with its byte address.
package isu_pkg;

  localparam int INSN_BYTES    = 4;
  localparam int FETCH_Q_DEPTH = 2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/isu_fetch_q.sv
// Two-entry fetch buffer; head always lives in slot 0.
// Slots beyond the current count are kept at zero.
module fetch_q
  import isu_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [A_WIDTH-1:0] push_pc,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [A_WIDTH-1:0] head_pc,
  output logic [D_WIDTH-1:0] head_data
);

  typedef struct packed {
    logic [A_WIDTH-1:0] pc;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  entry_t q0;
  entry_t q1;
  entry_t in;
  logic   do_pop;

  assign in         = '{pc: push_pc, data: push_data};
  assign do_pop     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);
  assign head_pc    = q0.pc;
  assign head_data  = q0.data;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q0    <= '0;
      q1    <= '0;
      count <= '0;
    end else begin
      case ({push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            q0 <= in;
          end else begin
            q0 <= q1;
            q1 <= in;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            q0    <= in;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            q1    <= in;
            count <= 2'(FETCH_Q_DEPTH);
          end
        end
        2'b01: begin
          q0    <= q1;
          q1    <= '0;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/isu_fetch.sv
// Fetch stage: owns the PC, issues ROM reads under a credit limit
// so the queue can always absorb the one outstanding return.
module isu_fetch
  import isu_pkg::*;
#(
  parameter int                 D_WIDTH  = 32,
  parameter int                 A_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [D_WIDTH-1:0] imem_dout,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [D_WIDTH-1:0] inst_data,
  output logic [A_WIDTH-1:0] inst_pc
);

  logic [A_WIDTH-1:0] pc;
  logic [A_WIDTH-1:0] req_pc;
  logic               req_q;
  logic [1:0]         count;
  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occ;

  assign pop  = inst_valid && inst_ready;
  assign push = req_q && !redirect_valid;

  // Slots already spoken for after this cycle's pop.
  assign occ = {1'b0, count} + {2'b0, req_q} - {2'b0, pop};

  assign issue = !rst && !redirect_valid
              && (occ < 3'(FETCH_Q_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      req_q  <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[A_WIDTH-1:2], 2'b00};
      req_q <= 1'b0;
    end else begin
      req_q <= issue;
      if (issue) begin
        pc     <= pc + A_WIDTH'(INSN_BYTES);
        req_pc <= pc;
      end
    end
  end

  fetch_q #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_q (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (req_pc),
    .push_data  (imem_dout),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_data  (inst_data)
  );

endmodule

// File: doc/isu_fetch.md
# isu_fetch

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream-facing to decode. Owns the program counter, issues one-cycle-latency reads to the ROM (`en`/`addr` → `dout` next cycle), and pairs each returned word with its PC. Returned words are buffered in a 2-entry queue and presented to decode over a valid/ready handshake. Supports redirect (branch/jump) with flush of in-flight and buffered words.

## Interface
- `D_WIDTH`, 32, instruction width.
- `A_WIDTH`, 32, byte-address width.
- `RESET_PC`, 32'h0, PC loaded on reset (word aligned).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_en`  out  1  ROM read enable (combinational from state).
- `imem_addr`  out  A_WIDTH  ROM byte address; equals current PC.
- `imem_dout`  in  D_WIDTH  ROM data; valid the cycle after `imem_en`.
- `redirect_valid`  in  1  load new PC, flush pipeline.
- `redirect_pc`  in  A_WIDTH  target PC; bits [1:0] ignored (forced 0).
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst_data`  out  D_WIDTH  head instruction.
- `inst_pc`  out  A_WIDTH  head instruction address.

## Operation
- State: `pc`, `req_q` (one read outstanding), `req_pc` (address of outstanding read), 2-entry queue {pc, data}, `count` (0..2).
- pop = `inst_valid & inst_ready`.
- Issue when `!rst & !redirect_valid & (count + req_q − pop) < 2`. On issue: `imem_en`=1, `imem_addr`=`pc`; `pc` ← `pc`+4 (modulo 2^A_WIDTH, wraps silently); `req_pc` ← `pc`; `req_q` ← 1. No issue → `imem_en`=0, `req_q` ← 0.
- Capture: when `req_q`=1 and no redirect, push {`req_pc`, `imem_dout`} into queue. Credit rule guarantees space; push and pop in same cycle both take effect.
- Redirect (highest priority, overrides issue/capture/pop bookkeeping): `pc` ← {`redirect_pc`[A_WIDTH−1:2], 2'b00}; queue emptied; `req_q` ← 0 (ROM data returning next cycle discarded); `imem_en`=0 this cycle. A pop handshake coinciding with redirect is a completed transfer from decode's view; the entry is then flushed with the rest.
- `imem_addr` driven with `pc` even when `imem_en`=0.

## Timing
- Reset values: `pc`=`RESET_PC`, `req_q`=0, `count`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, queue entries 0; `imem_en`=0 while `rst` high.
- Reset mid-operation: all of the above on the next edge; any returning ROM word dropped.
- First fetch: issue in first cycle after `rst` deasserts (cycle 0); word captured end of cycle 1; `inst_valid`=1 in cycle 2.
- Issue-to-valid latency 2 cycles; redirect in cycle N → issue N+1 → `inst_valid` N+3.
- Throughput: 1 instruction/cycle sustained with `inst_ready` held high (steady state count=1, req_q=1).
- Stall: `inst_ready`=0 → at most 2 buffered + 0 outstanding; `imem_en` drops; no word lost or duplicated; resumes full rate on the cycle `inst_ready` returns.
- `inst_*` stable while `inst_valid & !inst_ready`, unless redirect.

## Structure
- Package `isu_pkg`: `INSN_BYTES`=4, `FETCH_Q_DEPTH`=2, default `RESET_PC`, fetch-entry struct {pc, data}.
- Sub-module `fetch_q`: 2-entry synchronous FIFO with push/pop/flush, `count`, head outputs; reset and flush both clear to empty and zero entries. `isu_fetch` holds PC, request tracking and credit logic.

## Test plan
- Reset release, ROM word i = 0x1000_0000+i, `inst_ready`=1 → `inst_pc` 0x0,0x4,0x8… on consecutive cycles from cycle 2, `inst_data` 0x1000_0000,0x1000_0001,….
- `inst_ready`=0 for cycles 3–7 → `imem_en`=0 once count+req_q=2; on release, sequence continues with no gap, skip or repeat.
- Redirect to 0x43 while 2 entries buffered and a read outstanding → queue empty next cycle, next `imem_addr`=0x40, `inst_valid` 3 cycles later with `inst_pc`=0x40; stale words never appear.
- Redirect coincident with pop and capture → pop counted, captured word dropped, count=0.
- `RESET_PC`=0xFFFF_FFFC → pc wraps to 0x0 after first issue; `inst_pc` 0xFFFF_FFFC then 0x0.
- Assert `rst` with count=2, req_q=1 → all outputs at reset values next cycle; restart fetches from `RESET_PC`.
